// File: rtl/pc_sequencer.sv
// Fetch/issue/execute sequencer owning the core's program counter.
// Fetches over a req/ack handshake, issues one instruction, and advances pc on completion.
module pc_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    input  logic              exec_done,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_off,
    output logic              imem_req,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_EXEC, S_HALTED, S_ERROR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       fetch_to;

    // Ack wins over timeout in the last permitted FETCH cycle.
    assign fetch_to = (state == S_FETCH) && !imem_ack && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ack)      state_nxt = S_ISSUE;
                else if (fetch_to) state_nxt = S_ERROR;
            end
            S_ISSUE:  state_nxt = S_EXEC;
            S_EXEC:   if (exec_done) state_nxt = halt ? S_HALTED : S_FETCH;
            S_HALTED: if (start) state_nxt = S_FETCH;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            pc          <= '0;
            instr       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counter is zero outside FETCH, so every FETCH entry starts from zero.
            if (state == S_FETCH && state_nxt == S_FETCH)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
            if (state == S_FETCH && imem_ack)
                instr <= imem_data;
            // Adding the ADDR_W-bit offset is the sign-extended add modulo 2^ADDR_W.
            if (state == S_EXEC && exec_done)
                pc <= jump_en ? pc + jump_off : pc + ADDR_W'(1);
            if (fetch_to)
                timeout_err <= 1'b1;
        end
    end

    assign imem_req    = (state == S_FETCH);
    assign instr_valid = (state == S_ISSUE);
    assign busy        = (state == S_FETCH) || (state == S_ISSUE) || (state == S_EXEC);

endmodule
